// File: rtl/param_counter.sv
// Parametrised up/down counter with configurable modulus, prescaler, wrap or saturate
// limit handling, synchronous load/clear and wrap/overflow flags.
module param_counter #(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MOD      = 256,
  parameter int              SATURATE = 0,
  parameter int              PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_limit,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MOD - 64'd1);

  logic step;
  logic ovf_set;

  generate
    if (PRESCALE > 1) begin : g_pre
      localparam int            PW    = $clog2(PRESCALE);
      localparam logic [PW-1:0] PTERM = PW'(PRESCALE - 1);

      logic [PW-1:0] presc;

      // The interval restarts on clear and load so the next step is a full PRESCALE away.
      always_ff @(posedge clk) begin
        if (!rst || clear || load) begin
          presc <= '0;
        end else if (en) begin
          if (presc == PTERM) begin
            presc <= '0;
          end else begin
            presc <= presc + PW'(1);
          end
        end
      end

      assign step = en && (presc == PTERM);
    end else begin : g_nopre
      assign step = en;
    end
  endgenerate

  assign at_limit = up_dn ? (count == LIMIT) : (count == '0);

  // A step taken at a limit is what raises ovf, in both wrap and saturate modes.
  assign ovf_set = step && at_limit && !clear && !load;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clear) begin
        count <= '0;
      end else if (load) begin
        count <= (load_val > LIMIT) ? LIMIT : load_val;
      end else if (step) begin
        if (up_dn) begin
          if (count != LIMIT) begin
            count <= count + WIDTH'(1);
          end else if (SATURATE == 0) begin
            count <= '0;
            wrap  <= 1'b1;
          end
        end else begin
          if (count != '0) begin
            count <= count - WIDTH'(1);
          end else if (SATURATE == 0) begin
            count <= LIMIT;
            wrap  <= 1'b1;
          end
        end
      end
      ovf <= ovf_set || (ovf && !ovf_clr);
    end
  end

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter: three instances (wrap, saturate, prescale-by-4) checked every
// cycle against a behavioural model, plus hand-computed checkpoints.
module tb_param_counter;

  localparam int W    = 4;
  localparam int NI   = 3;
  localparam int MODV = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         en       [NI];
  logic         up_dn    [NI];
  logic         clear    [NI];
  logic         load     [NI];
  logic         ovf_clr  [NI];
  logic [W-1:0] load_val [NI];
  logic [W-1:0] count    [NI];
  logic         wrap     [NI];
  logic         at_limit [NI];
  logic         ovf      [NI];

  int compared   = 0;
  int mismatched = 0;

  int m_count [NI];
  int m_pre   [NI];
  bit m_wrap  [NI];
  bit m_ovf   [NI];
  bit model_valid = 1'b0;

  always #5 clk = ~clk;

  param_counter #(.WIDTH(W), .MOD(MODV), .SATURATE(0), .PRESCALE(1)) u_wrap (
    .clk(clk), .rst(rst), .en(en[0]), .up_dn(up_dn[0]), .clear(clear[0]), .load(load[0]),
    .load_val(load_val[0]), .ovf_clr(ovf_clr[0]), .count(count[0]), .wrap(wrap[0]),
    .at_limit(at_limit[0]), .ovf(ovf[0]));

  param_counter #(.WIDTH(W), .MOD(MODV), .SATURATE(1), .PRESCALE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en[1]), .up_dn(up_dn[1]), .clear(clear[1]), .load(load[1]),
    .load_val(load_val[1]), .ovf_clr(ovf_clr[1]), .count(count[1]), .wrap(wrap[1]),
    .at_limit(at_limit[1]), .ovf(ovf[1]));

  param_counter #(.WIDTH(W), .MOD(MODV), .SATURATE(0), .PRESCALE(4)) u_pre (
    .clk(clk), .rst(rst), .en(en[2]), .up_dn(up_dn[2]), .clear(clear[2]), .load(load[2]),
    .load_val(load_val[2]), .ovf_clr(ovf_clr[2]), .count(count[2]), .wrap(wrap[2]),
    .at_limit(at_limit[2]), .ovf(ovf[2]));

  function automatic bit sat_of(int i);
    return (i == 1);
  endfunction

  function automatic int pre_of(int i);
    return (i == 2) ? 4 : 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s t=%0t actual=%0d required=%0d", name, $time, actual, required);
    end
  endtask

  // Model: each enabled cycle advances a tick count; every PRESCALE-th one moves the
  // count one place around 0..MOD-1 (or pins it at the end in saturate mode).
  function automatic void model_edge(int i);
    bit hit_limit;
    if (!rst) begin
      m_count[i] = 0; m_pre[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
      return;
    end
    hit_limit = 0;
    m_wrap[i] = 0;
    if (clear[i]) begin
      m_count[i] = 0; m_pre[i] = 0;
    end else if (load[i]) begin
      m_count[i] = (int'(load_val[i]) >= MODV) ? MODV - 1 : int'(load_val[i]);
      m_pre[i] = 0;
    end else if (en[i]) begin
      m_pre[i] = (m_pre[i] + 1) % pre_of(i);
      if (m_pre[i] == 0) begin
        int target;
        target = up_dn[i] ? m_count[i] + 1 : m_count[i] - 1;
        if (target < 0 || target >= MODV) begin
          hit_limit = 1;
          if (!sat_of(i)) begin
            m_count[i] = (target + MODV) % MODV;
            m_wrap[i] = 1;
          end
        end else begin
          m_count[i] = target;
        end
      end
    end
    m_ovf[i] = hit_limit || (m_ovf[i] && !ovf_clr[i]);
  endfunction

  always @(posedge clk) begin
    if (!rst) model_valid = 1'b1;
    for (int i = 0; i < NI; i++) model_edge(i);
  end

  always @(negedge clk) begin
    if (model_valid) begin
      for (int i = 0; i < NI; i++) begin
        checkOutput($sformatf("count[%0d]", i), 32'(count[i]), 32'(m_count[i]));
        checkOutput($sformatf("wrap[%0d]", i), 32'(wrap[i]), 32'(m_wrap[i]));
        checkOutput($sformatf("ovf[%0d]", i), 32'(ovf[i]), 32'(m_ovf[i]));
        checkOutput($sformatf("at_limit[%0d]", i), 32'(at_limit[i]),
                    32'(up_dn[i] ? (m_count[i] == MODV - 1) : (m_count[i] == 0)));
      end
    end
  end

  task automatic applyStimulus(input int i, input bit e, input bit u, input bit c, input bit l,
                               input logic [W-1:0] lv, input bit oc);
    en[i] = e; up_dn[i] = u; clear[i] = c; load[i] = l; load_val[i] = lv; ovf_clr[i] = oc;
  endtask

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < NI; i++) applyStimulus(i, 0, 1, 0, 0, '0, 0);
    applyStimulus(0, 1, 1, 0, 0, '0, 0);

    // Reset held with en high
    cycle(2);
    checkOutput("reset_count", 32'(count[0]), 0);
    checkOutput("reset_wrap", 32'(wrap[0]), 0);
    checkOutput("reset_ovf", 32'(ovf[0]), 0);

    // Up count through wrap
    rst = 1'b1;
    cycle(1);
    checkOutput("up_first", 32'(count[0]), 1);
    cycle(8);
    checkOutput("up_nine", 32'(count[0]), 9);
    checkOutput("up_at_limit", 32'(at_limit[0]), 1);
    cycle(1);
    checkOutput("wrap_count", 32'(count[0]), 0);
    checkOutput("wrap_pulse", 32'(wrap[0]), 1);
    checkOutput("wrap_ovf", 32'(ovf[0]), 1);
    cycle(1);
    checkOutput("wrap_gone", 32'(wrap[0]), 0);

    // Load clamp and priority
    applyStimulus(0, 0, 1, 0, 1, 4'd13, 0);
    cycle(1);
    checkOutput("load_clamp", 32'(count[0]), 9);
    applyStimulus(0, 0, 1, 1, 1, 4'd13, 0);
    cycle(1);
    checkOutput("clear_over_load", 32'(count[0]), 0);
    applyStimulus(0, 1, 1, 0, 1, 4'd5, 0);
    cycle(1);
    checkOutput("load_no_step", 32'(count[0]), 5);
    applyStimulus(0, 1, 1, 0, 0, '0, 0);
    cycle(1);
    checkOutput("step_after_load", 32'(count[0]), 6);

    // Down wrap
    applyStimulus(0, 0, 0, 0, 1, 4'd0, 0);
    cycle(1);
    checkOutput("down_at_limit", 32'(at_limit[0]), 1);
    applyStimulus(0, 1, 0, 0, 0, '0, 0);
    cycle(1);
    checkOutput("down_wrap_count", 32'(count[0]), 9);
    checkOutput("down_wrap_pulse", 32'(wrap[0]), 1);

    // ovf set/clear race, then plain clear
    applyStimulus(0, 1, 1, 0, 0, '0, 1);
    cycle(1);
    checkOutput("race_count", 32'(count[0]), 0);
    checkOutput("race_ovf_kept", 32'(ovf[0]), 1);
    applyStimulus(0, 0, 1, 0, 0, '0, 1);
    cycle(1);
    checkOutput("ovf_cleared", 32'(ovf[0]), 0);
    applyStimulus(0, 0, 1, 0, 0, '0, 0);

    // Down saturate
    applyStimulus(1, 0, 0, 0, 1, 4'd2, 0);
    cycle(1);
    checkOutput("sat_load", 32'(count[1]), 2);
    applyStimulus(1, 1, 0, 0, 0, '0, 0);
    cycle(2);
    checkOutput("sat_zero", 32'(count[1]), 0);
    checkOutput("sat_at_limit", 32'(at_limit[1]), 1);
    checkOutput("sat_ovf_not_yet", 32'(ovf[1]), 0);
    cycle(1);
    checkOutput("sat_hold", 32'(count[1]), 0);
    checkOutput("sat_no_wrap", 32'(wrap[1]), 0);
    checkOutput("sat_ovf", 32'(ovf[1]), 1);
    cycle(2);
    applyStimulus(1, 0, 1, 0, 1, 4'd9, 0);
    cycle(1);
    applyStimulus(1, 1, 1, 0, 0, '0, 1);
    cycle(1);
    checkOutput("sat_up_hold", 32'(count[1]), 9);
    checkOutput("sat_up_ovf", 32'(ovf[1]), 1);
    applyStimulus(1, 0, 1, 0, 0, '0, 0);

    // Prescale by 4, en gap, clear mid-interval, direction change mid-interval
    applyStimulus(2, 1, 1, 0, 0, '0, 0);
    cycle(3);
    checkOutput("pre_wait", 32'(count[2]), 0);
    cycle(1);
    checkOutput("pre_first_step", 32'(count[2]), 1);
    cycle(2);
    applyStimulus(2, 0, 1, 0, 0, '0, 0);
    cycle(3);
    applyStimulus(2, 1, 1, 0, 0, '0, 0);
    cycle(1);
    checkOutput("pre_delayed", 32'(count[2]), 1);
    cycle(1);
    checkOutput("pre_second_step", 32'(count[2]), 2);
    cycle(2);
    applyStimulus(2, 1, 1, 1, 0, '0, 0);
    cycle(1);
    checkOutput("pre_clear", 32'(count[2]), 0);
    applyStimulus(2, 1, 1, 0, 0, '0, 0);
    cycle(3);
    checkOutput("pre_restart_wait", 32'(count[2]), 0);
    cycle(1);
    checkOutput("pre_restart_step", 32'(count[2]), 1);
    cycle(2);
    applyStimulus(2, 1, 0, 0, 0, '0, 0);
    cycle(1);
    checkOutput("pre_dir_pending", 32'(count[2]), 1);
    cycle(1);
    checkOutput("pre_dir_step", 32'(count[2]), 0);

    // Reset mid-operation
    for (int i = 0; i < NI; i++) applyStimulus(i, 1, 1, 0, 0, '0, 0);
    rst = 1'b0;
    cycle(1);
    checkOutput("midrst_count", 32'(count[1]), 0);
    checkOutput("midrst_ovf", 32'(ovf[1]), 0);
    rst = 1'b1;
    cycle(1);
    checkOutput("resume_p1", 32'(count[0]), 1);
    checkOutput("resume_p4", 32'(count[2]), 0);
    for (int i = 0; i < NI; i++) applyStimulus(i, 0, 1, 0, 0, '0, 0);
    cycle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
